split_scan_ctrl: RTL

Sequencer for the generated `split_N` constraint checkers. It walks a contiguous range of candidate assignments through one combinational checker, one candidate per cycle. Each satisfying candidate is captured into a single-entry output buffer with a valid/ready handshake. It counts tested and satisfying candidates, so the solver front-end can sweep and cross-check split partitions without hand-driving each one.

---
 rtl/split_scan_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/split_scan_ctrl.sv
// split_scan_ctrl: sweeps a contiguous candidate range through an external
// combinational checker and buffers each satisfying candidate behind valid/ready.
`default_nettype none

module split_scan_ctrl #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic         first_only_i,
  input  logic [W-1:0] base_i,
  input  logic [W:0]   span_i,
  output logic [W-1:0] cand_o,
  input  logic         chk_x_i,
  output logic         sol_valid_o,
  input  logic         sol_ready_i,
  output logic [W-1:0] sol_data_o,
  output logic         busy_o,
  output logic         done_o,
  output logic [W:0]   tested_cnt_o,
  output logic [W:0]   hit_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [W-1:0] ONE_W = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W:0]   ONE_C = {{W{1'b0}}, 1'b1};
  localparam logic [W:0]   ZERO_C = '0;

  state_e       state_q, state_d;
  logic [W-1:0] cand_q, cand_d;
  logic [W:0]   remaining_q, remaining_d;
  logic         first_only_q, first_only_d;
  logic         sol_valid_q, sol_valid_d;
  logic [W-1:0] sol_data_q, sol_data_d;
  logic [W:0]   tested_q, tested_d;
  logic [W:0]   hit_q, hit_d;

  logic free;
  logic test;
  logic hit;
  logic last;

  always_comb begin
    state_d      = state_q;
    cand_d       = cand_q;
    remaining_d  = remaining_q;
    first_only_d = first_only_q;
    sol_valid_d  = sol_valid_q;
    sol_data_d   = sol_data_q;
    tested_d     = tested_q;
    hit_d        = hit_q;

    free = !sol_valid_q || sol_ready_i;
    // Abort suppresses the test so counters hold exactly as they were.
    test = (state_q == S_SCAN) && free && !abort_i;
    hit  = test && chk_x_i;
    last = test && ((remaining_q == ONE_C) || (chk_x_i && first_only_q));

    if (sol_valid_q && sol_ready_i) begin
      sol_valid_d = 1'b0;
    end

    if (test) begin
      tested_d    = tested_q + ONE_C;
      remaining_d = remaining_q - ONE_C;
      cand_d      = cand_q + ONE_W;
    end

    // A hit reloads the slot even when it is being drained this same cycle.
    if (hit) begin
      sol_data_d  = cand_q;
      sol_valid_d = 1'b1;
      hit_d       = hit_q + ONE_C;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          first_only_d = first_only_i;
          cand_d       = base_i;
          remaining_d  = span_i;
          tested_d     = '0;
          hit_d        = '0;
          state_d      = (span_i == ZERO_C) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        if (last) begin
          state_d = sol_valid_d ? S_DRAIN : S_DONE;
        end
      end
      S_DRAIN: begin
        if (!sol_valid_d) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_i) begin
      state_d     = S_IDLE;
      sol_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cand_q       <= '0;
      remaining_q  <= '0;
      first_only_q <= 1'b0;
      sol_valid_q  <= 1'b0;
      sol_data_q   <= '0;
      tested_q     <= '0;
      hit_q        <= '0;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      remaining_q  <= remaining_d;
      first_only_q <= first_only_d;
      sol_valid_q  <= sol_valid_d;
      sol_data_q   <= sol_data_d;
      tested_q     <= tested_d;
      hit_q        <= hit_d;
    end
  end

  assign cand_o       = cand_q;
  assign sol_valid_o  = sol_valid_q;
  assign sol_data_o   = sol_data_q;
  assign busy_o       = (state_q == S_SCAN) || (state_q == S_DRAIN);
  assign done_o       = (state_q == S_DONE);
  assign tested_cnt_o = tested_q;
  assign hit_cnt_o    = hit_q;

endmodule

`default_nettype wire
